// File: rtl/display_seq_pkg.sv
// Shared types and constants for the display sequencer.
// Holds the FSM and page enums, HEX3 labels, and page digit decode helpers.
package display_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_SHOW
  } state_t;

  typedef enum logic [1:0] {
    PG_A,
    PG_B,
    PG_C,
    PG_D
  } page_t;

  localparam logic [6:0] HEX3_A    = 7'b0001000;
  localparam logic [6:0] HEX3_B    = 7'b0000000;
  localparam logic [6:0] HEX3_C    = 7'b1000110;
  localparam logic [6:0] HEX3_D    = 7'b1000000;
  localparam logic [6:0] HEX3_DASH = 7'b0111111;

  localparam logic [3:0]  BCD_BLANK = 4'hF;
  localparam logic [11:0] HEX_BLANK = {3{BCD_BLANK}};

  function automatic logic [11:0] page_digits(
    input logic [43:0] s,
    input page_t       p
  );
    logic [11:0] d;
    d = HEX_BLANK;
    unique case (p)
      PG_A: d = {BCD_BLANK, s[43:36]};
      PG_B: d = s[35:24];
      PG_C: d = s[23:12];
      PG_D: d = s[11:0];
      default: d = HEX_BLANK;
    endcase
    return d;
  endfunction

  function automatic logic [6:0] page_label(
    input page_t p
  );
    logic [6:0] l;
    l = HEX3_DASH;
    unique case (p)
      PG_A: l = HEX3_A;
      PG_B: l = HEX3_B;
      PG_C: l = HEX3_C;
      PG_D: l = HEX3_D;
      default: l = HEX3_DASH;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/display_sequencer_btn_debounce.sv
// Button synchronizer and debouncer; output is the accepted stable level.
// Ports: CLOCK_50, reset_n, btn (raw, async), level (debounced, 1=released).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic btn,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt counts consecutive clocks the synced input differs from level
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_sequencer.sv
// Sequences conversion, snapshot capture and four-page HEX display.
// Ports: CLOCK_50, reset_n, toggleBtn, conv_done, bcd_in -> run, conv_start, page, hex_digits, hex3, conv_err.
module display_sequencer
  import display_seq_pkg::*;
#(
  parameter int DWELL_CYCLES    = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        toggleBtn,
  input  logic        conv_done,
  input  logic [43:0] bcd_in,
  output logic        run,
  output logic        conv_start,
  output logic [1:0]  page,
  output logic [11:0] hex_digits,
  output logic [6:0]  hex3,
  output logic        conv_err
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  page_t         page_q, page_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [43:0]   snap_q;
  logic          snap_valid_q;
  logic          snap_load;
  logic          err_set;
  logic          btn_level;
  logic          btn_prev;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .CLOCK_50(CLOCK_50),
    .reset_n (reset_n),
    .btn     (toggleBtn),
    .level   (btn_level)
  );

  assign page = page_q;

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    dcnt_d     = dcnt_q;
    tcnt_d     = tcnt_q;
    snap_load  = 1'b0;
    err_set    = 1'b0;
    conv_start = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_START;
      S_START: begin
        tcnt_d = '0;
        dcnt_d = '0;
        page_d = PG_A;
        if (run) begin
          conv_start = 1'b1;
          state_d    = S_WAIT;
        end else begin
          state_d = S_SHOW;
        end
      end
      S_WAIT: begin
        // conv_done wins over a timeout landing on the same cycle
        if (conv_done) begin
          snap_load = 1'b1;
          state_d   = S_SHOW;
        end else if (tcnt_q == T_LAST) begin
          err_set = 1'b1;
          state_d = S_SHOW;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (dcnt_q == D_LAST) begin
          dcnt_d = '0;
          page_d = page_t'(page_q + 2'd1);
          if (page_q == PG_D) state_d = S_START;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      page_q       <= PG_A;
      dcnt_q       <= '0;
      tcnt_q       <= '0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      conv_err     <= 1'b0;
      run          <= 1'b1;
      btn_prev     <= 1'b1;
      hex_digits   <= HEX_BLANK;
      hex3         <= HEX3_DASH;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      dcnt_q   <= dcnt_d;
      tcnt_q   <= tcnt_d;
      btn_prev <= btn_level;
      if (btn_prev && !btn_level) run <= ~run;
      if (err_set) conv_err <= 1'b1;
      if (snap_load) begin
        snap_q       <= bcd_in;
        snap_valid_q <= 1'b1;
      end
      // keyed on page_d so page and digits move on the same edge;
      // uses the pre-load snapshot, giving 2-cycle latency from conv_done
      if (snap_valid_q) begin
        hex_digits <= page_digits(snap_q, page_d);
        hex3       <= page_label(page_d);
      end else begin
        hex_digits <= HEX_BLANK;
        hex3       <= HEX3_DASH;
      end
    end
  end

endmodule

// File: tb/tb_display_sequencer.sv
// Self-checking bench for display_sequencer with small parameters.
// Randomized BCD snapshots and reply delays checked against a page model.
module tb_display_sequencer;

  localparam int DW = 8;
  localparam int DB = 4;
  localparam int TO = 16;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        toggleBtn = 1'b1;
  logic        conv_done = 1'b0;
  logic [43:0] bcd_in = '0;
  logic        run;
  logic        conv_start;
  logic [1:0]  page;
  logic [11:0] hex_digits;
  logic [6:0]  hex3;
  logic        conv_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic        exp_valid = 1'b0;
  logic [43:0] exp_snap = '0;

  display_sequencer #(
    .DWELL_CYCLES   (DW),
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .toggleBtn (toggleBtn),
    .conv_done (conv_done),
    .bcd_in    (bcd_in),
    .run       (run),
    .conv_start(conv_start),
    .page      (page),
    .hex_digits(hex_digits),
    .hex3      (hex3),
    .conv_err  (conv_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [3:0] dig(input int i);
    logic [43:0] t;
    t = exp_snap >> (4 * i);
    return t[3:0];
  endfunction

  function automatic logic [11:0] exp_hex(input int p);
    if (!exp_valid) return 12'hFFF;
    case (p)
      0: return {4'hF, dig(10), dig(9)};
      1: return {dig(8), dig(7), dig(6)};
      2: return {dig(5), dig(4), dig(3)};
      default: return {dig(2), dig(1), dig(0)};
    endcase
  endfunction

  function automatic logic [6:0] exp_hex3(input int p);
    if (!exp_valid) return 7'b0111111;
    case (p)
      0: return 7'b0001000;
      1: return 7'b0000000;
      2: return 7'b1000110;
      default: return 7'b1000000;
    endcase
  endfunction

  function automatic logic [43:0] rand_bcd();
    logic [43:0] s;
    s = '0;
    for (int i = 0; i < 11; i++)
      s[4*i +: 4] = 4'($urandom_range(0, 9));
    return s;
  endfunction

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    conv_done = 1'b0;
    toggleBtn = 1'b1;
    repeat (2) tick();
    exp_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic wait_start(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (conv_start === 1'b1) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic wait_page(output int cyc);
    logic [1:0] p0;
    p0 = page;
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (page !== p0) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic pulse_done(input logic [43:0] v);
    bcd_in = v;
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
  endtask

  task automatic press(input int n);
    toggleBtn = 1'b0;
    repeat (n) tick();
    toggleBtn = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    conv_done = 1'b0;
    toggleBtn = 1'b1;
    repeat (2) tick();
    n_cmp++; if (run !== 1'b1) begin n_bad++;
      $display("FAIL rst_run: got %b want 1", run); end
    n_cmp++; if (conv_start !== 1'b0) begin n_bad++;
      $display("FAIL rst_start: got %b want 0", conv_start); end
    n_cmp++; if (page !== 2'd0) begin n_bad++;
      $display("FAIL rst_page: got %0d want 0", page); end
    n_cmp++; if (hex_digits !== 12'hFFF) begin n_bad++;
      $display("FAIL rst_hex: got %h want fff", hex_digits); end
    n_cmp++; if (hex3 !== 7'b0111111) begin n_bad++;
      $display("FAIL rst_hex3: got %b want 0111111", hex3); end
    n_cmp++; if (conv_err !== 1'b0) begin n_bad++;
      $display("FAIL rst_err: got %b want 0", conv_err); end
    exp_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_conversion();
    int c;
    int d;
    logic [43:0] v;
    wait_start(c);
    n_cmp++; if (c !== 1) begin n_bad++;
      $display("FAIL start_latency: got %0d want 1", c); end
    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin
        tick();
        n_cmp++; if (conv_start !== 1'b0) begin n_bad++;
          $display("FAIL start_width: got %b want 0", conv_start); end
        repeat (2) tick();
        v = 44'h123_4567_8901;
      end else begin
        d = $urandom_range(1, TO - 1);
        repeat (d) tick();
        v = rand_bcd();
      end
      pulse_done(v);
      exp_valid = 1'b1;
      exp_snap = v;
      tick();
      n_cmp++; if (page !== 2'd0 || hex_digits !== exp_hex(0) || hex3 !== exp_hex3(0)) begin
        n_bad++;
        $display("FAIL conv_pageA r%0d: got p%0d %h %b want p0 %h %b",
                 r, page, hex_digits, hex3, exp_hex(0), exp_hex3(0));
      end
      for (int p = 1; p < 4; p++) begin
        wait_page(c);
        n_cmp++; if (page !== 2'(p) || hex_digits !== exp_hex(p) || hex3 !== exp_hex3(p)) begin
          n_bad++;
          $display("FAIL conv_page r%0d p%0d: got p%0d %h %b want %h %b",
                   r, p, page, hex_digits, hex3, exp_hex(p), exp_hex3(p));
        end
        n_cmp++; if (c !== ((p == 1) ? DW - 1 : DW)) begin n_bad++;
          $display("FAIL dwell r%0d p%0d: got %0d cycles want %0d",
                   r, p, c, (p == 1) ? DW - 1 : DW);
        end
      end
      wait_start(c);
      n_cmp++; if (c !== DW || page !== 2'd0) begin n_bad++;
        $display("FAIL restart r%0d: got %0d cycles page %0d want %0d page 0",
                 r, c, page, DW);
      end
    end
  endtask

  task automatic test_timeout();
    int c;
    do_reset();
    wait_start(c);
    c = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (conv_err === 1'b1) begin c = i; break; end
    end
    n_cmp++; if (c !== TO + 1) begin n_bad++;
      $display("FAIL timeout_cycles: got %0d want %0d", c, TO + 1); end
    n_cmp++; if (hex_digits !== 12'hFFF || hex3 !== 7'b0111111) begin n_bad++;
      $display("FAIL timeout_blank: got %h %b want fff 0111111", hex_digits, hex3); end
    for (int p = 1; p < 4; p++) begin
      wait_page(c);
      n_cmp++; if (page !== 2'(p) || hex_digits !== exp_hex(p) || hex3 !== exp_hex3(p)) begin
        n_bad++;
        $display("FAIL timeout_page p%0d: got p%0d %h %b want %h %b",
                 p, page, hex_digits, hex3, exp_hex(p), exp_hex3(p));
      end
    end
    wait_start(c);
    n_cmp++; if (c !== DW || conv_err !== 1'b1) begin n_bad++;
      $display("FAIL timeout_restart: got %0d err %b want %0d err 1", c, conv_err, DW); end
  endtask

  task automatic test_button();
    int c;
    int starts;
    logic [43:0] v;
    do_reset();
    wait_start(c);
    repeat (2) tick();
    v = rand_bcd();
    pulse_done(v);
    exp_valid = 1'b1;
    exp_snap = v;
    tick();
    press(2);
    repeat (10) tick();
    n_cmp++; if (run !== 1'b1) begin n_bad++;
      $display("FAIL short_press: got run %b want 1", run); end
    press(6);
    repeat (12) tick();
    n_cmp++; if (run !== 1'b0) begin n_bad++;
      $display("FAIL long_press: got run %b want 0", run); end
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (conv_start === 1'b1) starts++;
    end
    n_cmp++; if (starts !== 0) begin n_bad++;
      $display("FAIL run0_starts: got %0d want 0", starts); end
    c = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (page === 2'd1) begin c = i; break; end
    end
    n_cmp++; if (c < 0 || hex_digits !== exp_hex(1) || hex3 !== exp_hex3(1)) begin
      n_bad++;
      $display("FAIL held_snap: got %h %b (%0d) want %h %b",
               hex_digits, hex3, c, exp_hex(1), exp_hex3(1));
    end
    press(6);
    repeat (12) tick();
    n_cmp++; if (run !== 1'b1) begin n_bad++;
      $display("FAIL repress: got run %b want 1", run); end
    wait_start(c);
    n_cmp++; if (c < 0) begin n_bad++;
      $display("FAIL resume_start: got %0d want conv_start", c); end
  endtask

  task automatic test_done_on_timeout();
    int c;
    logic [43:0] v;
    do_reset();
    wait_start(c);
    repeat (TO) tick();
    v = rand_bcd();
    pulse_done(v);
    exp_valid = 1'b1;
    exp_snap = v;
    n_cmp++; if (conv_err !== 1'b0) begin n_bad++;
      $display("FAIL edge_err: got %b want 0", conv_err); end
    tick();
    n_cmp++; if (page !== 2'd0 || hex_digits !== exp_hex(0) || hex3 !== exp_hex3(0)) begin
      n_bad++;
      $display("FAIL edge_latch: got p%0d %h %b want p0 %h %b",
               page, hex_digits, hex3, exp_hex(0), exp_hex3(0));
    end
    repeat (2) tick();
    pulse_done(rand_bcd() ^ 44'h111_1111_1111);
    wait_page(c);
    n_cmp++; if (hex_digits !== exp_hex(1) || conv_err !== 1'b0) begin n_bad++;
      $display("FAIL stray_done: got %h err %b want %h err 0",
               hex_digits, conv_err, exp_hex(1));
    end
  endtask

  task automatic test_reset_mid();
    int c;
    logic [43:0] v;
    do_reset();
    wait_start(c);
    repeat (2) tick();
    v = rand_bcd();
    pulse_done(v);
    exp_valid = 1'b1;
    exp_snap = v;
    tick();
    press(6);
    c = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (page === 2'd2) begin c = i; break; end
    end
    repeat (2) tick();
    n_cmp++; if (c < 0 || run !== 1'b0 || hex_digits !== exp_hex(2)) begin n_bad++;
      $display("FAIL pre_rst: got %0d run %b %h want page C run 0 %h",
               c, run, hex_digits, exp_hex(2));
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (page !== 2'd0 || hex_digits !== 12'hFFF || hex3 !== 7'b0111111
                 || run !== 1'b1 || conv_err !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst: got p%0d %h %b run %b err %b want p0 fff 0111111 1 0",
               page, hex_digits, hex3, run, conv_err);
    end
    exp_valid = 1'b0;
    do_reset();
    wait_start(c);
    repeat (4) tick();
    reset_n = 1'b0;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (conv_start !== 1'b0) c++;
    end
    n_cmp++; if (c !== 0) begin n_bad++;
      $display("FAIL wait_rst_start: got %0d pulses want 0", c); end
    reset_n = 1'b1;
    wait_start(c);
    n_cmp++; if (c !== 1) begin n_bad++;
      $display("FAIL wait_rst_restart: got %0d want 1", c); end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_timeout();
    test_button();
    test_done_on_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_sequencer.md
# display_sequencer

Controller that sequences the board's counter display path: it debounces the start/stop button into a `run` enable, drives the binary-to-BCD converter with a start/done handshake, and captures a consistent 11-digit snapshot. It then pages that snapshot across HEX3..HEX0 in four dwell-timed pages. It sits between the free-running counter/BCD converter and the seven-segment decoders, replacing the ad-hoc slow-clock paging logic with a single-clock controller.

## Interface
- `DWELL_CYCLES`, 25_000_000: clocks each page is shown (0.5 s at 50 MHz).
- `DEBOUNCE_CYCLES`, 500_000: clocks the synchronized button must be stable before it is accepted.
- `TIMEOUT_CYCLES`, 1024: maximum wait for `conv_done` after `conv_start`.
- `CLOCK_50`  in  1  sole clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `toggleBtn`  in  1  raw push-button, active-low, asynchronous to `CLOCK_50`.
- `conv_done`  in  1  one-cycle pulse from the converter: `bcd_in` is valid.
- `bcd_in`  in  44  11 BCD digits; `[3:0]` is BCD0, `[43:40]` is BCD10.
- `run`  out  1  enable to the counter and filter datapath.
- `conv_start`  out  1  one-cycle request to the converter.
- `page`  out  2  current page: 0=A, 1=B, 2=C, 3=D.
- `hex_digits`  out  12  three BCD codes for HEX2/HEX1/HEX0 (`[11:8]`=HEX2).
- `hex3`  out  7  active-low segment pattern for the page label.
- `conv_err`  out  1  sticky; set on a converter timeout.

## Operation
- Button path:
  - 2-flop synchronizer, then a debounce counter; a level is accepted after `DEBOUNCE_CYCLES` stable clocks.
  - Each accepted 1→0 transition toggles `run`.
  - Releasing the button has no effect.
- FSM states: `IDLE` → `START` → `WAIT` → `SHOW`.
- `IDLE`: entered from reset; moves to `START` on the next clock.
- `START`:
  - If `run`=1, pulse `conv_start` for exactly one cycle and go to `WAIT`.
  - If `run`=0, skip conversion, keep the old snapshot, and go to `SHOW`.
- `WAIT`:
  - On `conv_done`, latch all 44 bits of `bcd_in` into the snapshot and go to `SHOW`.
  - After `TIMEOUT_CYCLES` with no `conv_done`, keep the old snapshot, set `conv_err`, and go to `SHOW`.
- `SHOW`:
  - Dwell counter runs 0..`DWELL_CYCLES`-1.
  - At terminal count, `page` advances A→B→C→D.
  - On D at terminal count, `page` wraps to A and the FSM returns to `START`, so every full rotation shows one coherent snapshot.
- Page map (snapshot digits, HEX2/HEX1/HEX0; `hex3` label):
  - A: F, BCD10, BCD9; `hex3`=7'b0001000.
  - B: BCD8, BCD7, BCD6; `hex3`=7'b0000000.
  - C: BCD5, BCD4, BCD3; `hex3`=7'b1000110.
  - D: BCD2, BCD1, BCD0; `hex3`=7'b1000000.
  - 4'hF is the blank code.
- Before the first successful snapshot, `hex_digits`=12'hFFF and `hex3`=7'b0111111 (dash) on all pages.
- Reset values:
  - `run`=1, `conv_start`=0, `page`=0, `hex_digits`=12'hFFF, `hex3`=7'b0111111, `conv_err`=0.
  - Snapshot valid flag=0; FSM=`IDLE`; all counters 0.
  - Debounced button level=1 (released).

## Timing
- `conv_start` is high the single cycle after the FSM enters `START`.
- Snapshot is updated on the clock edge where `conv_done`=1 in `WAIT`.
  - `hex_digits`/`hex3` reflect the new snapshot on the following edge.
  - Page A is displayed then, giving 2-cycle latency from `conv_done`.
- `page`, `hex_digits` and `hex3` are registered and change on the same edge.
- Simultaneous events:
  - `conv_done` on the timeout cycle: `conv_done` wins and `conv_err` is not set.
  - `conv_done` outside `WAIT`: ignored.
  - A button toggle during `WAIT`/`SHOW` changes `run` immediately, but only affects the next `START` decision.
- Reset asserted mid-`WAIT` or mid-dwell: all outputs go to their reset values asynchronously, and no `conv_start` is issued until `START` is re-entered.
- Dwell and timeout counters are sized as $clog2 of their parameters. Parameters ≥2 are required.

## Structure
- Shared package `display_seq_pkg`:
  - FSM state enum and page enum.
  - `HEX3` label constants for A–D and dash.
  - `BCD_BLANK` = 4'hF.
- Sub-module `btn_debounce` (sync plus debounce, output is the stable level). The edge detect and toggle stay in `display_sequencer`.

## Test plan
All scenarios use `DWELL_CYCLES`=8, `DEBOUNCE_CYCLES`=4, `TIMEOUT_CYCLES`=16.
- Release reset, `run`=1 → `conv_start` pulses once. Reply `conv_done` 3 cycles later with `bcd_in`=44'h123_4567_8901 → `hex_digits`=F,1,2 with `hex3`=A pattern, then 3,4,5 / 6,7,8 / 9,0,1 at 8-cycle spacing. A new `conv_start` is issued after D.
- Never assert `conv_done` → `conv_err`=1 after 16 cycles. Display stays dashes and 12'hFFF, and pages still rotate.
- Hold `toggleBtn` low for 2 cycles, then for 6 cycles → only the second press toggles `run` to 0. Next rotation issues no `conv_start` and the snapshot is held.
- Assert `conv_done` on the exact timeout cycle → snapshot latched and `conv_err` stays 0.
- Assert `reset_n`=0 during `SHOW` on page C → `page`=0, `hex_digits`=12'hFFF, `hex3`=7'b0111111 and `run`=1 immediately, without waiting for a clock edge.
